// File: rtl/wfg_wb_master_pkg.sv
// Shared types and defaults for the waveform generator Wishbone initiator.
package wfg_wb_master_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wb_master_state_t;

  localparam int unsigned WB_TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/wfg_wb_master.sv
// Wishbone classic single-transfer initiator: one command in, one bus cycle,
// one response out (read data or timeout error).
module wfg_wb_master
  import wfg_wb_master_pkg::*;
#(
  parameter int BUSW    = 32,
  parameter int TIMEOUT = WB_TIMEOUT_DEFAULT
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [BUSW-1:0]   cmd_adr_i,
  input  logic [BUSW-1:0]   cmd_dat_i,
  input  logic [BUSW/8-1:0] cmd_sel_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [BUSW-1:0]   rsp_dat_o,
  output logic              rsp_err_o,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  output logic [BUSW/8-1:0] wbm_sel_o,
  output logic [BUSW-1:0]   wbm_adr_o,
  output logic [BUSW-1:0]   wbm_dat_o,
  input  logic              wbm_ack_i,
  input  logic [BUSW-1:0]   wbm_dat_i
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  wb_master_state_t  state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              cyc_q, cyc_d;
  logic              we_q, we_d;
  logic [BUSW-1:0]   adr_q, adr_d;
  logic [BUSW-1:0]   dat_q, dat_d;
  logic [BUSW/8-1:0] sel_q, sel_d;
  logic [BUSW-1:0]   rsp_dat_q, rsp_dat_d;
  logic              rsp_err_q, rsp_err_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cyc_d     = cyc_q;
    we_d      = we_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    sel_d     = sel_q;
    rsp_dat_d = rsp_dat_q;
    rsp_err_d = rsp_err_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          we_d    = cmd_we_i;
          adr_d   = cmd_adr_i;
          dat_d   = cmd_dat_i;
          sel_d   = cmd_sel_i;
          cyc_d   = 1'b1;
          cnt_d   = '0;
          state_d = BUS;
        end
      end
      BUS: begin
        // Ack is checked first so an ack in the last allowed cycle still succeeds.
        if (wbm_ack_i) begin
          rsp_dat_d = we_q ? '0 : wbm_dat_i;
          rsp_err_d = 1'b0;
          cyc_d     = 1'b0;
          we_d      = 1'b0;
          state_d   = RESP;
        end else if (cnt_q == CNT_LAST) begin
          rsp_dat_d = '0;
          rsp_err_d = 1'b1;
          cyc_d     = 1'b0;
          we_d      = 1'b0;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      rsp_dat_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      sel_q     <= sel_d;
      rsp_dat_q <= rsp_dat_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  // Response valid comes straight from the state register, so it is registered.
  assign cmd_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_err_o   = rsp_err_q;
  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = cyc_q;
  assign wbm_we_o    = we_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;
  assign wbm_sel_o   = sel_q;

endmodule

// File: doc/wfg_wb_master.md
# wfg_wb_master

Wishbone classic single-transfer initiator for the waveform generator. It accepts one register access command at a time on a valid/ready interface and runs one Wishbone read or write cycle against a peripheral register block. It returns read data, or a timeout error, on a response valid/ready interface. It sits between the configuration sequencer and the peripheral register slaves.

## Interface
- BUSW, 32: Wishbone data/address width; must be a multiple of 8.
- TIMEOUT, 16: maximum cycles with `wbm_stb_o` high before the transfer is aborted; must be at least 2.
- Clock and reset: one clock; reset is synchronous and active-high.
- `wb_clk_i` in 1: clock.
- `wb_rst_i` in 1: synchronous active-high reset.
- `cmd_valid_i` in 1: command present.
- `cmd_ready_o` out 1: command accepted when high together with `cmd_valid_i`.
- `cmd_we_i` in 1: 1 = write, 0 = read.
- `cmd_adr_i` in BUSW: target address.
- `cmd_dat_i` in BUSW: write data.
- `cmd_sel_i` in BUSW/8: byte selects.
- `rsp_valid_o` out 1: response present.
- `rsp_ready_i` in 1: response consumed when high together with `rsp_valid_o`.
- `rsp_dat_o` out BUSW: read data; 0 for writes and for errors.
- `rsp_err_o` out 1: transfer timed out.
- `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o` out 1: Wishbone bus controls.
- `wbm_sel_o` out BUSW/8: byte selects.
- `wbm_adr_o`, `wbm_dat_o` out BUSW: address and write data.
- `wbm_ack_i` in 1: slave acknowledge.
- `wbm_dat_i` in BUSW: slave read data.

## Operation
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - `cmd_ready_o` = 1; it is 0 in every other state.
  - On handshake: register we/adr/dat/sel onto the `wbm_*` outputs, set cyc = stb = 1, clear the timeout counter, go to BUS.
- BUS:
  - cyc, stb and all `wbm_*` outputs are held stable.
  - `wbm_ack_i` is sampled only in this state.
  - Ack = 1: capture `wbm_dat_i` into `rsp_dat_o` if read, else 0. Set `rsp_err_o` = 0, drop cyc/stb/we, go to RESP.
  - No ack and counter = TIMEOUT-1: set `rsp_dat_o` = 0, `rsp_err_o` = 1, drop cyc/stb/we, go to RESP.
  - Otherwise the counter increments.
  - Ack in the final timeout cycle wins over the error.
- RESP:
  - `rsp_valid_o` = 1; outputs are held until `rsp_ready_i` = 1, then go to IDLE.
  - Acks arriving here are ignored. This covers slaves that keep acking while they still see stb.
- `wbm_adr_o`, `wbm_dat_o` and `wbm_sel_o` may keep their last values outside BUS. `wbm_we_o` is 0 outside BUS.
- Counter width is $clog2(TIMEOUT); it never wraps because the exit happens at TIMEOUT-1.
- Reset in any state:
  - Next state is IDLE.
  - cyc, stb, we, `rsp_valid_o` and `rsp_err_o` = 0.
  - `rsp_dat_o`, `wbm_adr_o`, `wbm_dat_o` and `wbm_sel_o` = 0.
  - An in-flight transfer is dropped and produces no response.

## Timing
- All outputs are registered except `cmd_ready_o`, which is decoded from state.
- Cycle 0: command handshake. Cycle 1: cyc/stb high.
- With a slave that acks one cycle after stb (registered ack): ack arrives in cycle 2, `rsp_valid_o` and cyc low in cycle 3. Command-to-response latency is 3 cycles.
- Zero-wait slave (ack in cycle 1): response in cycle 2.
- Timeout: stb is high for exactly TIMEOUT cycles (cycles 1..TIMEOUT); `rsp_valid_o` rises in cycle TIMEOUT+1.
- If `rsp_ready_i` is already high, a new command is accepted at the earliest the cycle after the response handshake. Throughput is at most one transfer per 4 cycles with a registered-ack slave.

## Structure
- Package `wfg_wb_master_pkg` holds:
  - `wb_master_state_t` enum (IDLE, BUS, RESP).
  - Localparam for the default timeout.
- No sub-module. A single FSM plus counter belongs in one module.
- The bench provides a behavioural Wishbone responder with configurable ack delay (0, 1 or never) and a small register array.

## Test plan
- Write: cmd we=1, adr=0x3, dat=0x4000, sel=0xF, responder with registered ack:
  - cyc/stb high in cycles 1–2.
  - Responder register 0x3 = 0x4000.
  - Response in cycle 3 with err=0, dat=0.
- Read: after the write above, cmd we=0, adr=0x3 → `rsp_dat_o` = 0x00004000, err=0, latency 3 cycles.
- Timeout: TIMEOUT=16, responder never acks:
  - stb high for exactly 16 cycles.
  - Response err=1, dat=0.
  - Late acks are ignored.
- Ack in the last cycle: ack arrives in stb cycle 16 → err=0, read data captured.
- Backpressure: `rsp_ready_i` held low for 5 cycles:
  - `rsp_valid_o` and the data stay stable.
  - `cmd_ready_o` stays 0; a second command waits.
  - After release, the second command is accepted the following cycle.
- Reset mid-BUS: assert `wb_rst_i` in cycle 2 of a read:
  - Next cycle cyc, stb, we and `rsp_valid_o` are all 0 and `cmd_ready_o` = 1.
  - No response is emitted.
